// File: rtl/mips_pkg.sv
// Shared MIPS core constants: datapath width, register-file geometry
// and the architecturally special register indices.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    localparam logic [REG_AW-1:0] REG_ZERO   = 5'd0;
    localparam logic [REG_AW-1:0] REG_SW     = 5'd1;
    localparam logic [REG_AW-1:0] REG_DISP_A = 5'd2;
    localparam logic [REG_AW-1:0] REG_DISP_B = 5'd3;
    localparam logic [REG_AW-1:0] REG_RA     = 5'd31;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: decode indices, write-back data,
// read results and the board I/O window ($1 switches, $2/$3 display).
interface reg_file_if;
    import mips_pkg::*;

    logic                  RegW;
    logic [REG_AW-1:0]     DR;
    logic [REG_AW-1:0]     SR1;
    logic [REG_AW-1:0]     SR2;
    logic [DATA_W-1:0]     Reg_In;
    logic [DATA_W-1:0]     ReadReg1;
    logic [DATA_W-1:0]     ReadReg2;
    logic [2:0]            r1;
    logic [DATA_W-1:0]     r2;
    logic [DATA_W-1:0]     r3;

    modport master (
        output RegW, DR, SR1, SR2, Reg_In, r1,
        input  ReadReg1, ReadReg2, r2, r3
    );

    modport slave (
        input  RegW, DR, SR1, SR2, Reg_In, r1,
        output ReadReg1, ReadReg2, r2, r3
    );

endinterface

// File: rtl/reg_file.sv
// 32 x 32 register file: two combinational read ports, one clocked write.
// $0 reads zero, $1 reads the switches, $2/$3 are tapped for display.
module reg_file
    import mips_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    reg_file_if.slave  bus
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] raw1;
    logic [DATA_W-1:0] raw2;

    // $0 and $1 never come from storage; everything else does.
    function automatic logic [DATA_W-1:0] rd_mux(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] raw,
        input logic [2:0]        sw
    );
        logic [DATA_W-1:0] v;
        v = raw;
        if (idx == REG_ZERO)
            v = '0;
        else if (idx == REG_SW)
            v = {{(DATA_W-3){1'b0}}, sw};
        return v;
    endfunction

    // Next array state: reset clears, otherwise write $2..$31 only.
    always_comb begin
        regs_d = regs_q;
        if (RST) begin
            for (int i = 0; i < NREGS; i++)
                regs_d[i] = '0;
        end else if (bus.RegW && (bus.DR > REG_SW)) begin
            regs_d[bus.DR] = bus.Reg_In;
        end
    end

    // Array state register.
    always_ff @(posedge CLK) begin
        regs_q <= regs_d;
    end

    assign raw1 = regs_q[bus.SR1];
    assign raw2 = regs_q[bus.SR2];

    assign bus.ReadReg1 = rd_mux(bus.SR1, raw1, bus.r1);
    assign bus.ReadReg2 = rd_mux(bus.SR2, raw2, bus.r1);
    assign bus.r2       = regs_q[REG_DISP_A];
    assign bus.r3       = regs_q[REG_DISP_B];

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized check of reg_file against an array model
// of the architectural register rules.
module tb_reg_file;
    import mips_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] m [32];

    reg_file_if bus ();

    reg_file u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (idx == 5'd1) return {29'b0, bus.r1};
        return m[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        #1;
        chk({tag, ".rd1"}, bus.ReadReg1, mread(bus.SR1));
        chk({tag, ".rd2"}, bus.ReadReg2, mread(bus.SR2));
        chk({tag, ".r2"},  bus.r2, m[2]);
        chk({tag, ".r3"},  bus.r3, m[3]);
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 32; i++) m[i] = 32'h0;
        end else if (bus.RegW && bus.DR >= 5'd2) begin
            m[bus.DR] = bus.Reg_In;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] d, input logic [31:0] v);
        bus.RegW = 1'b1; bus.DR = d; bus.Reg_In = v;
        tick();
        bus.RegW = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        RST = 1'b1;
        bus.RegW = 1'b0; bus.DR = '0; bus.Reg_In = '0;
        bus.SR1 = '0; bus.SR2 = '0; bus.r1 = 3'b101;
        tick();
        RST = 1'b0;

        bus.SR1 = 5'd1; bus.SR2 = 5'd7; #1;
        chk("rst.sw", bus.ReadReg1, 32'h5);
        chk("rst.r7", bus.ReadReg2, 32'h0);
        chk("rst.r2", bus.r2, 32'h0);
        chk("rst.r3", bus.r3, 32'h0);

        bus.RegW = 1'b1; bus.DR = 5'd5; bus.Reg_In = 32'hDEADBEEF;
        bus.SR1 = 5'd5; bus.SR2 = 5'd5; #1;
        chk("wr.old", bus.ReadReg1, 32'h0);
        tick();
        bus.RegW = 1'b0; #1;
        chk("wr.rd1", bus.ReadReg1, 32'hDEADBEEF);
        chk("wr.rd2", bus.ReadReg2, 32'hDEADBEEF);

        bus.r1 = 3'b010;
        wr(5'd0, 32'hFFFFFFFF);
        wr(5'd1, 32'hFFFFFFFF);
        bus.SR1 = 5'd0; bus.SR2 = 5'd1; #1;
        chk("prot.r0", bus.ReadReg1, 32'h0);
        chk("prot.r1", bus.ReadReg2, 32'h2);
        bus.r1 = 3'b111; #1;
        chk("prot.sw7", bus.ReadReg2, 32'h7);

        wr(5'd2, 32'h12345678);
        chk("disp.r2", bus.r2, 32'h12345678);
        wr(5'd3, 32'h0000ABCD);
        chk("disp.r3", bus.r3, 32'h0000ABCD);
        chk("disp.r2b", bus.r2, 32'h12345678);

        wr(5'd31, 32'hAAAA5555);
        bus.SR1 = 5'd31; bus.SR2 = 5'd31;
        bus.RegW = 1'b0; bus.DR = 5'd31; bus.Reg_In = 32'h1;
        tick();
        chk("we.gate", bus.ReadReg1, 32'hAAAA5555);
        RST = 1'b1; bus.RegW = 1'b1;
        tick();
        RST = 1'b0; bus.RegW = 1'b0; #1;
        chk("rst.prio", bus.ReadReg1, 32'h0);
        chk("rst.r2", bus.r2, 32'h0);
        wr(5'd31, 32'h7F);
        chk("ra.7f", bus.ReadReg2, 32'h7F);

        for (int n = 0; n < 300; n++) begin
            RST        = ($urandom_range(0, 24) == 0);
            bus.RegW   = $urandom_range(0, 2) != 0;
            bus.DR     = 5'($urandom_range(0, 31));
            bus.Reg_In = $urandom;
            bus.SR1    = 5'($urandom_range(0, 31));
            bus.SR2    = ($urandom_range(0, 3) == 0) ? bus.SR1
                                                      : 5'($urandom_range(0, 31));
            bus.r1     = 3'($urandom_range(0, 7));
            chk_all("rnd.pre");
            tick();
            chk_all("rnd.post");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
